bcd_display_counter: RTL and testbench

//   Consumer stage for the frequency divider's slow clock output.
//   - Detects rising edges of tick_in synchronously in the clk_intput domain.
//   - Steps a 4-digit BCD up/down counter (0000-9999) once per detected edge.
//   - Drives a time-multiplexed, common-anode 4-digit 7-segment display.
//   - tick_in is never used as a clock.

---
 rtl/bcd_display_counter_if.sv | 22 ++
 rtl/bcd_display_counter.sv | 159 +++++++++++++++
 tb/tb_bcd_display_counter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/bcd_display_counter_if.sv
// Control and display bundle for bcd_display_counter.
// master drives tick/controls; slave returns count and display lines.
interface bcd_display_counter_if;
  logic        tick_in;
  logic        en;
  logic        up_dn;
  logic        clear;
  logic [15:0] bcd_value;
  logic        wrap;
  logic [3:0]  an;
  logic [6:0]  seg;

  modport master (
    output tick_in, en, up_dn, clear,
    input  bcd_value, wrap, an, seg
  );

  modport slave (
    input  tick_in, en, up_dn, clear,
    output bcd_value, wrap, an, seg
  );
endinterface

// File: rtl/bcd_display_counter.sv
// 4-digit BCD up/down counter stepped by a synchronized tick, with muxed 7-seg.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits above d0.
module bcd_display_counter #(
  parameter int SCAN_DIV    = 50000,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk_intput,
  input  logic               rst,
  bcd_display_counter_if.slave bus
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (v[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    logic        b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (b) begin
        if (v[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = 4'd9;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   hist_q;
  logic                   evt_q;
  logic                   last;
  logic                   last_ok;

  assign last    = sync_q[SYNC_STAGES-1];
  assign last_ok = fill_q[SYNC_STAGES-1];

  // History reads as high until the chain holds post-reset samples,
  // so a tick already high at release is not taken as an edge.
  always_ff @(posedge clk_intput) begin
    if (rst) begin
      sync_q <= '0;
      fill_q <= '0;
      hist_q <= 1'b0;
      evt_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.tick_in};
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      hist_q <= last_ok ? last : 1'b1;
      evt_q  <= last_ok & last & ~hist_q;
    end
  end

  logic [15:0] bcd_q;
  logic        wrap_q;

  always_ff @(posedge clk_intput) begin
    if (rst) begin
      bcd_q  <= '0;
      wrap_q <= 1'b0;
    end else if (bus.clear) begin
      bcd_q  <= '0;
      wrap_q <= 1'b0;
    end else if (evt_q && bus.en && bus.up_dn) begin
      bcd_q  <= bcd_inc(bcd_q);
      wrap_q <= (bcd_q == 16'h9999);
    end else if (evt_q && bus.en) begin
      bcd_q  <= bcd_dec(bcd_q);
      wrap_q <= (bcd_q == 16'h0000);
    end else begin
      wrap_q <= 1'b0;
    end
  end

  logic [CW-1:0] scan_q;
  logic [1:0]    idx_q;
  logic [3:0]    an_q;
  logic [6:0]    seg_q;
  logic [3:0]    digit;
  logic          blank;

  assign digit = bcd_q[{idx_q, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  logic [3:0] lz;
  assign lz[3] = (bcd_q[15:12] == 4'd0);
  assign lz[2] = lz[3] & (bcd_q[11:8] == 4'd0);
  assign lz[1] = lz[2] & (bcd_q[7:4] == 4'd0);
  assign lz[0] = 1'b0;
  assign blank = lz[idx_q];
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge clk_intput) begin
    if (rst) begin
      scan_q <= '0;
      idx_q  <= 2'd0;
      an_q   <= 4'b1111;
      seg_q  <= 7'b1111111;
    end else begin
      if (scan_q == SCAN_LAST) begin
        scan_q <= '0;
        idx_q  <= idx_q + 2'd1;
      end else begin
        scan_q <= scan_q + 1'b1;
      end
      an_q  <= ~(4'b0001 << idx_q);
      seg_q <= blank ? 7'b1111111 : ~seg_of(digit);
    end
  end

  assign bus.bcd_value = bcd_q;
  assign bus.wrap      = wrap_q;
  assign bus.an        = an_q;
  assign bus.seg       = seg_q;

endmodule

// File: tb/tb_bcd_display_counter.sv
// Directed bench for bcd_display_counter with SCAN_DIV=4, SYNC_STAGES=2.
// Checks reset, latency, carry/borrow, wrap, en, clear priority, scan.
module tb_bcd_display_counter;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  bcd_display_counter_if bus();

  bcd_display_counter #(
    .SCAN_DIV    (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk_intput (clk),
    .rst        (rst),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] ZHI = 7'h7F;
`else
  localparam logic [6:0] ZHI = 7'h40;
`endif

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick_land();
    bus.tick_in = 1'b1;
    step(2);
    bus.tick_in = 1'b0;
    step(2);
  endtask

  task automatic tick_pulse();
    tick_land();
    step(2);
  endtask

  task automatic scan4(input logic [6:0] s0, input logic [6:0] s1,
                       input logic [6:0] s2, input logic [6:0] s3);
    logic [6:0] s [4];
    logic [3:0] a;
    int         n;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    n = 0;
    while (bus.an !== 4'b0111 && n < 40) begin
      step(1);
      n++;
    end
    while (bus.an !== 4'b1110 && n < 40) begin
      step(1);
      n++;
    end
    chk("scan_sync", {12'd0, bus.an}, 16'h000E);
    for (int k = 0; k < 4; k++) begin
      a = ~(4'b0001 << k);
      chk("scan_an", {12'd0, bus.an}, {12'd0, a});
      chk("scan_seg", {9'd0, bus.seg}, {9'd0, s[k]});
      step(3);
      chk("scan_an_hold", {12'd0, bus.an}, {12'd0, a});
      step(1);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.tick_in = 1'b0;
    bus.en = 1'b0;
    bus.up_dn = 1'b0;
    bus.clear = 1'b0;
    step(3);
    chk("rst_bcd", bus.bcd_value, 16'h0000);
    chk("rst_wrap", {15'd0, bus.wrap}, 16'h0000);
    chk("rst_an", {12'd0, bus.an}, 16'h000F);
    chk("rst_seg", {9'd0, bus.seg}, 16'h007F);
    rst = 1'b0;
    step(1);
    chk("rel_an", {12'd0, bus.an}, 16'h000E);
    chk("rel_seg", {9'd0, bus.seg}, 16'h0040);

    bus.en = 1'b1;
    bus.up_dn = 1'b1;
    bus.tick_in = 1'b1;
    step(2);
    bus.tick_in = 1'b0;
    step(1);
    chk("lat_edge3", bus.bcd_value, 16'h0000);
    step(1);
    chk("lat_edge4", bus.bcd_value, 16'h0001);
    step(2);
    for (int i = 0; i < 11; i++) tick_pulse();
    chk("up_12", bus.bcd_value, 16'h0012);
    scan4(7'h24, 7'h79, ZHI, ZHI);

    bus.up_dn = 1'b0;
    for (int i = 0; i < 3; i++) tick_pulse();
    chk("borrow_09", bus.bcd_value, 16'h0009);
    bus.up_dn = 1'b1;
    tick_pulse();
    chk("carry_10", bus.bcd_value, 16'h0010);

    bus.clear = 1'b1;
    step(1);
    bus.clear = 1'b0;
    chk("clear", bus.bcd_value, 16'h0000);

    bus.up_dn = 1'b0;
    tick_land();
    chk("dn_wrap_val", bus.bcd_value, 16'h9999);
    chk("dn_wrap_pulse", {15'd0, bus.wrap}, 16'h0001);
    step(1);
    chk("dn_wrap_end", {15'd0, bus.wrap}, 16'h0000);
    step(1);

    bus.en = 1'b0;
    tick_pulse();
    chk("en_low_hold", bus.bcd_value, 16'h9999);
    bus.en = 1'b1;
    tick_pulse();
    chk("dn_9998", bus.bcd_value, 16'h9998);

    bus.up_dn = 1'b1;
    tick_land();
    chk("up_9999", bus.bcd_value, 16'h9999);
    chk("up_9999_nowrap", {15'd0, bus.wrap}, 16'h0000);
    step(2);
    tick_land();
    chk("up_wrap_val", bus.bcd_value, 16'h0000);
    chk("up_wrap_pulse", {15'd0, bus.wrap}, 16'h0001);
    step(1);
    chk("up_wrap_end", {15'd0, bus.wrap}, 16'h0000);
    step(1);

    bus.tick_in = 1'b1;
    step(2);
    bus.tick_in = 1'b0;
    step(1);
    bus.clear = 1'b1;
    step(1);
    bus.clear = 1'b0;
    chk("clr_evt_val", bus.bcd_value, 16'h0000);
    chk("clr_evt_wrap", {15'd0, bus.wrap}, 16'h0000);
    step(3);
    chk("clr_evt_after", bus.bcd_value, 16'h0000);

    rst = 1'b1;
    bus.tick_in = 1'b1;
    step(2);
    rst = 1'b0;
    step(8);
    chk("tick_high_rel", bus.bcd_value, 16'h0000);
    bus.tick_in = 1'b0;
    step(4);
    tick_pulse();
    chk("post_rel_tick", bus.bcd_value, 16'h0001);

    for (int i = 0; i < 1233; i++) tick_pulse();
    chk("up_1234", bus.bcd_value, 16'h1234);
    scan4(7'h19, 7'h30, 7'h24, 7'h79);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
